// File: rtl/mandelbrot_scheduler.sv
// Frame-level pixel scheduler: walks a pixel grid, dispatches c values to iteration cores and
// streams tagged escape counts. Define MANDEL_SCHED_PERF_EN to add frame perf counters.
module mandelbrot_scheduler #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_ITER_WIDTH = 16,
  parameter int unsigned COORD_WIDTH    = 12
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [DATA_WIDTH-1:0]                x_start_i,
  input  logic [DATA_WIDTH-1:0]                y_start_i,
  input  logic [DATA_WIDTH-1:0]                step_i,
  input  logic [COORD_WIDTH-1:0]               width_i,
  input  logic [COORD_WIDTH-1:0]               height_i,
  input  logic [MAX_ITER_WIDTH-1:0]            max_iter_i,
  output logic                                 busy_o,
  output logic                                 frame_done_o,
  output logic [NUM_CORES-1:0]                 core_start_o,
  output logic [NUM_CORES*DATA_WIDTH-1:0]      core_x0_o,
  output logic [NUM_CORES*DATA_WIDTH-1:0]      core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0]            core_max_iter_o,
  input  logic [NUM_CORES*MAX_ITER_WIDTH-1:0]  core_iter_i,
  input  logic [NUM_CORES-1:0]                 core_done_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [COORD_WIDTH-1:0]               res_col_o,
  output logic [COORD_WIDTH-1:0]               res_row_o,
  output logic [MAX_ITER_WIDTH-1:0]            res_iter_o
`ifdef MANDEL_SCHED_PERF_EN
  ,
  output logic [31:0]                          perf_cycles_o,
  output logic [31:0]                          perf_iters_o
`endif
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned MW    = MAX_ITER_WIDTH;
  localparam int unsigned CW    = COORD_WIDTH;
  localparam int unsigned IdxW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned IdxW1 = IdxW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  typedef enum logic [1:0] {SlotFree, SlotLaunch, SlotWait, SlotHold} slot_e;

  state_e            state_q, state_d;
  slot_e             slot_q [NUM_CORES];
  slot_e             slot_d [NUM_CORES];
  logic [DW-1:0]     xs_q, step_q, x_acc_q, y_acc_q;
  logic [CW-1:0]     width_q, height_q, col_q, row_q;
  logic [MW-1:0]     max_iter_q;
  logic [DW-1:0]     slot_x_q [NUM_CORES];
  logic [DW-1:0]     slot_y_q [NUM_CORES];
  logic [CW-1:0]     slot_col_q [NUM_CORES];
  logic [CW-1:0]     slot_row_q [NUM_CORES];
  logic [MW-1:0]     slot_iter_q [NUM_CORES];
  logic              res_valid_q, frame_done_q;
  logic [CW-1:0]     res_col_q, res_row_q;
  logic [MW-1:0]     res_iter_q;
  logic [IdxW-1:0]   res_slot_q, rr_q, rr_next, scan_base, free_idx, grant_idx;
  logic [IdxW1-1:0]  scan_idx;
  logic              free_found, grant_found, dispatch, accept, load;
  logic              last_col, last_row, all_free, frame_start;

  assign frame_start = (state_q == StIdle) && start_i;
  assign accept      = res_valid_q && res_ready_i;
  assign load        = !res_valid_q || accept;
  assign last_col    = (col_q == width_q - CW'(1));
  assign last_row    = (row_q == height_q - CW'(1));
  assign dispatch    = (state_q == StRun) && free_found;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    all_free   = 1'b1;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (slot_q[i] != SlotFree) all_free = 1'b0;
      if (!free_found && slot_q[i] == SlotFree) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Round-robin scan of HOLD slots, skipping the slot already sitting in the output register.
  always_comb begin
    rr_next     = (res_slot_q == IdxW'(NUM_CORES - 1)) ? '0 : res_slot_q + IdxW'(1);
    scan_base   = accept ? rr_next : rr_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      scan_idx = {1'b0, scan_base} + IdxW1'(i);
      if (scan_idx >= IdxW1'(NUM_CORES)) scan_idx = scan_idx - IdxW1'(NUM_CORES);
      if (!grant_found && slot_q[scan_idx[IdxW-1:0]] == SlotHold &&
          !(res_valid_q && scan_idx[IdxW-1:0] == res_slot_q)) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = (width_i == '0 || height_i == '0) ? StDone : StRun;
      StRun:   if (dispatch && last_col && last_row) state_d = StDrain;
      StDrain: if (all_free && !res_valid_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The core still presents its previous done during LAUNCH, so only WAIT looks at it.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      slot_d[k] = slot_q[k];
      unique case (slot_q[k])
        SlotFree:   if (dispatch && free_idx == IdxW'(k)) slot_d[k] = SlotLaunch;
        SlotLaunch: slot_d[k] = SlotWait;
        SlotWait:   if (core_done_i[k]) slot_d[k] = SlotHold;
        SlotHold:   if (accept && res_slot_q == IdxW'(k)) slot_d[k] = SlotFree;
        default:    slot_d[k] = SlotFree;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      slot_q       <= '{default: SlotFree};
      xs_q         <= '0;
      step_q       <= '0;
      x_acc_q      <= '0;
      y_acc_q      <= '0;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      max_iter_q   <= '0;
      slot_x_q     <= '{default: '0};
      slot_y_q     <= '{default: '0};
      slot_col_q   <= '{default: '0};
      slot_row_q   <= '{default: '0};
      slot_iter_q  <= '{default: '0};
      res_valid_q  <= 1'b0;
      res_col_q    <= '0;
      res_row_q    <= '0;
      res_iter_q   <= '0;
      res_slot_q   <= '0;
      rr_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      frame_done_q <= (state_q == StDone);
      if (frame_start) begin
        xs_q       <= x_start_i;
        step_q     <= step_i;
        width_q    <= width_i;
        height_q   <= height_i;
        max_iter_q <= max_iter_i;
        col_q      <= '0;
        row_q      <= '0;
        x_acc_q    <= x_start_i;
        y_acc_q    <= y_start_i;
      end
      if (dispatch) begin
        slot_x_q[free_idx]   <= x_acc_q;
        slot_y_q[free_idx]   <= y_acc_q;
        slot_col_q[free_idx] <= col_q;
        slot_row_q[free_idx] <= row_q;
        if (last_col) begin
          col_q   <= '0;
          row_q   <= row_q + CW'(1);
          x_acc_q <= xs_q;
          y_acc_q <= y_acc_q - step_q;
        end else begin
          col_q   <= col_q + CW'(1);
          x_acc_q <= x_acc_q + step_q;
        end
      end
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        if (slot_q[k] == SlotWait && core_done_i[k]) slot_iter_q[k] <= core_iter_i[k*MW +: MW];
      end
      if (accept) rr_q <= rr_next;
      if (load) begin
        res_valid_q <= grant_found;
        res_slot_q  <= grant_idx;
        res_col_q   <= slot_col_q[grant_idx];
        res_row_q   <= slot_row_q[grant_idx];
        res_iter_q  <= slot_iter_q[grant_idx];
      end
    end
  end

  always_comb begin
    core_start_o = '0;
    core_x0_o    = '0;
    core_y0_o    = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      core_start_o[k]         = (slot_q[k] == SlotLaunch);
      core_x0_o[k*DW +: DW]   = slot_x_q[k];
      core_y0_o[k*DW +: DW]   = slot_y_q[k];
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign frame_done_o    = frame_done_q;
  assign core_max_iter_o = max_iter_q;
  assign res_valid_o     = res_valid_q;
  assign res_col_o       = res_col_q;
  assign res_row_o       = res_row_q;
  assign res_iter_o      = res_iter_q;

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_iters_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_q <= '0;
      perf_iters_q  <= '0;
    end else if (frame_start) begin
      perf_cycles_q <= '0;
      perf_iters_q  <= '0;
    end else begin
      if (busy_o) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (accept) perf_iters_q <= perf_iters_q + 32'(res_iter_q);
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_iters_o  = perf_iters_q;
`endif

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Self-checking bench for mandelbrot_scheduler: behavioural cores, raster-order dispatch model
// and a tag scoreboard for results. Perf checks run when MANDEL_SCHED_PERF_EN is defined.
module tb_mandelbrot_scheduler;

  localparam int NC = 4;

  logic              clk, rst, start;
  logic [31:0]       x_start, y_start, step;
  logic [11:0]       width, height;
  logic [15:0]       max_iter;
  logic              busy, frame_done;
  logic [NC-1:0]     core_start;
  logic [NC*32-1:0]  core_x0, core_y0;
  logic [15:0]       core_max_iter;
  logic [NC*16-1:0]  core_iter;
  logic [NC-1:0]     core_done;
  logic              res_valid, res_ready;
  logic [11:0]       res_col, res_row;
  logic [15:0]       res_iter;
`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0]       perf_cycles, perf_iters;
`endif

  mandelbrot_scheduler #(
    .NUM_CORES(NC), .DATA_WIDTH(32), .MAX_ITER_WIDTH(16), .COORD_WIDTH(12)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .x_start_i(x_start), .y_start_i(y_start), .step_i(step),
    .width_i(width), .height_i(height), .max_iter_i(max_iter),
    .busy_o(busy), .frame_done_o(frame_done),
    .core_start_o(core_start), .core_x0_o(core_x0), .core_y0_o(core_y0),
    .core_max_iter_o(core_max_iter), .core_iter_i(core_iter), .core_done_i(core_done),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_col_o(res_col), .res_row_o(res_row), .res_iter_o(res_iter)
`ifdef MANDEL_SCHED_PERF_EN
    , .perf_cycles_o(perf_cycles), .perf_iters_o(perf_iters)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame model state
  logic [31:0] m_xs, m_ys, m_step;
  int          m_w, m_h, m_max;
  int          disp_n, delivered, done_pulses, busy_cycles, starts_total, ready_pct;
  int          pend [int];
  logic [31:0] log_x [4];
  logic [31:0] log_y [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Escape-time count in Q16.16: stop when |z|^2 > 4 or the limit is reached.
  function automatic int model_iter(input logic [31:0] x, input logic [31:0] y, input int maxit);
    longint cr, ci, zr, zi, zr2, zi2, t;
    int n;
    cr = longint'(signed'(x));
    ci = longint'(signed'(y));
    zr = 0; zi = 0; n = 0;
    while (n < maxit) begin
      zr2 = (zr * zr) >>> 16;
      zi2 = (zi * zi) >>> 16;
      if (zr2 + zi2 > (longint'(4) <<< 16)) break;
      t  = zr2 - zi2 + cr;
      zi = ((2 * zr * zi) >>> 16) + ci;
      zr = t;
      n++;
    end
    return n;
  endfunction

  // Behavioural cores: done stays at its old level through the start cycle.
  logic [31:0] cx [NC];
  logic [31:0] cy [NC];
  int          cnt [NC];
  bit          lpend [NC];
  initial begin
    core_done = '0;
    core_iter = '0;
    for (int k = 0; k < NC; k++) begin cnt[k] = 0; lpend[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (rst) begin
          core_done[k] = 1'b0; cnt[k] = 0; lpend[k] = 0;
        end else if (core_start[k]) begin
          lpend[k] = 1; cx[k] = core_x0[k*32 +: 32]; cy[k] = core_y0[k*32 +: 32];
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            core_iter[k*16 +: 16] = 16'(model_iter(cx[k], cy[k], int'(core_max_iter)));
            core_done[k] = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < NC; k++) begin
        if (lpend[k] && !rst) begin
          lpend[k] = 0; core_done[k] = 1'b0; cnt[k] = $urandom_range(1, 5);
        end
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      res_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Compare process: dispatch order/coordinates, result tags/iters, output stability.
  logic        prev_valid, prev_ready;
  logic [39:0] prev_data;
  always @(negedge clk) begin
    int col, row, key;
    logic [31:0] ex, ey;
    if (rst) begin
      prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      check("one_start_per_cycle", 64'($countones(core_start) <= 1), 1);
      for (int k = 0; k < NC; k++) begin
        if (core_start[k]) begin
          starts_total++;
          check("dispatch_in_frame", 64'(disp_n < m_w * m_h), 1);
          if (disp_n < m_w * m_h) begin
            col = disp_n % m_w;
            row = disp_n / m_w;
            ex  = m_xs + 32'(col) * m_step;
            ey  = m_ys - 32'(row) * m_step;
            check("dispatch_x0", core_x0[k*32 +: 32], ex);
            check("dispatch_y0", core_y0[k*32 +: 32], ey);
            pend[row * 4096 + col] = model_iter(ex, ey, m_max);
            if (disp_n < 4) begin log_x[disp_n] = core_x0[k*32 +: 32]; log_y[disp_n] = core_y0[k*32 +: 32]; end
            disp_n++;
          end
        end
      end
      if (busy) begin
        busy_cycles++;
        check("core_max_iter", core_max_iter, 64'(m_max));
      end
      if (prev_valid && !prev_ready) begin
        check("res_hold_valid", res_valid, 1);
        check("res_hold_data", {res_col, res_row, res_iter}, prev_data);
      end
      if (res_valid && res_ready) begin
        key = int'(res_row) * 4096 + int'(res_col);
        check("res_tag_known", 64'(pend.exists(key)), 1);
        if (pend.exists(key)) begin
          check("res_iter", res_iter, 64'(pend[key]));
          pend.delete(key);
          delivered++;
        end
      end
      if (frame_done) done_pulses++;
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_data  = {res_col, res_row, res_iter};
    end
  end

  task automatic start_frame(input logic [31:0] xs, input logic [31:0] ys, input logic [31:0] st,
                             input int w, input int h, input int mi);
    m_xs = xs; m_ys = ys; m_step = st; m_w = w; m_h = h; m_max = mi;
    disp_n = 0; delivered = 0; done_pulses = 0; busy_cycles = 0; starts_total = 0;
    pend.delete();
    x_start = xs; y_start = ys; step = st;
    width = 12'(w); height = 12'(h); max_iter = 16'(mi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (done_pulses == 0 && n < 4000) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_pulses), 1);
    check({name, "_dispatched"}, 64'(disp_n), 64'(m_w * m_h));
    check({name, "_delivered"}, 64'(delivered), 64'(m_w * m_h));
    check({name, "_busy"}, busy, 0);
  endtask

  logic [31:0] geo_x [4] = '{32'hFFFE0000, 32'hFFFE4000, 32'hFFFE0000, 32'hFFFE4000};
  logic [31:0] geo_y [4] = '{32'h00010000, 32'h00010000, 32'h0000C000, 32'h0000C000};

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ready_pct = 100;
    x_start = '0; y_start = '0; step = '0; width = '0; height = '0; max_iter = '0;
    m_w = 0; m_h = 0; m_max = 0; disp_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_core_start", core_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_core_x0", core_x0[63:0], 0);
    check("rst_max_iter", core_max_iter, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed pins on the iteration model.
    check("model_origin", 64'(model_iter(32'h0, 32'h0, 20)), 20);
    check("model_m2_p1i", 64'(model_iter(32'hFFFE0000, 32'h00010000, 20)), 1);
    check("model_lim0", 64'(model_iter(32'h0, 32'h0, 0)), 0);

    // Geometry
    start_frame(32'hFFFE0000, 32'h00010000, 32'h00004000, 2, 2, 20);
    wait_frame("geom");
    for (int i = 0; i < 4; i++) begin
      check("geom_x0_literal", log_x[i], geo_x[i]);
      check("geom_y0_literal", log_y[i], geo_y[i]);
    end

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      ready_pct = $urandom_range(30, 100);
      start_frame(32'hFFFD8000 + 32'($urandom_range(0, 32'h30000)),
                  32'hFFFF0000 + 32'($urandom_range(0, 32'h20000)),
                  32'($urandom_range(32'h800, 32'h8000)),
                  $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 30));
      wait_frame("rand");
    end

    // Backpressure
    ready_pct = 0;
    start_frame(32'hFFFF0000, 32'h00004000, 32'h00002000, 8, 1, 16);
    repeat (50) @(posedge clk);
    #1;
    check("bp_starts", 64'(starts_total), 4);
    check("bp_valid", res_valid, 1);
    ready_pct = 100;
    wait_frame("bp");

    // Zero iteration limit
    ready_pct = 70;
    start_frame(32'hFFFE8000, 32'h00008000, 32'h00004000, 4, 4, 0);
    wait_frame("iter0");

    // Empty frame
    start_frame(32'h0, 32'h0, 32'h00001000, 0, 3, 5);
    check("w0_done_early", frame_done, 0);
    @(posedge clk); #1;
    check("w0_done_pulse", frame_done, 1);
    @(posedge clk); #1;
    check("w0_done_fall", frame_done, 0);
    wait_frame("w0");
    check("w0_no_starts", 64'(starts_total), 0);

    // Start while busy
    ready_pct = 60;
    start_frame(32'hFFFF0000, 32'h00008000, 32'h00003000, 5, 3, 25);
    repeat (3) @(posedge clk);
    #1;
    x_start = 32'h00100000; step = 32'h00010000; width = 12'd2; height = 12'd2; max_iter = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame("busy_start");

    // Reset during drain
    ready_pct = 100;
    start_frame(32'hFFFE0000, 32'h00008000, 32'h00002000, 6, 2, 40);
    n = 0;
    while (disp_n < 12 && n < 500) begin @(posedge clk); #1; n++; end
    check("drain_reached", 64'(disp_n), 12);
    check("drain_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", {res_col, res_row, res_iter}, 0);
    check("mid_rst_core_xy", {core_x0, core_y0}, 0);
    check("mid_rst_max_iter", core_max_iter, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ready_pct = 80;
    start_frame(32'hFFFE8000, 32'hFFFF8000, 32'h00006000, 3, 3, 30);
    wait_frame("post_rst");

`ifdef MANDEL_SCHED_PERF_EN
    begin
      int s;
      s = 0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          s += model_iter(32'hFFFF0000 + 32'(c) * 32'h00008000,
                          32'h00008000 - 32'(r) * 32'h00008000, 25);
      ready_pct = 50;
      start_frame(32'hFFFF0000, 32'h00008000, 32'h00008000, 2, 2, 25);
      wait_frame("perf");
      check("perf_iters", perf_iters, 64'(s));
      check("perf_cycles", perf_cycles, 64'(busy_cycles));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
